// File: rtl/sdf_stage_ctrl.sv
// Control sequencer for one radix-2 single-path delay-feedback FWHT stage.
// Follows the input sample stream. Drives the butterfly phase select, the
// FIFO push/pop strobes and the input-register enable. Also flags the first
// and last stage output of each frame. A frame is 2*D samples, D = 2**M_WIDTH.
//
// Ports:
//   i_clk, i_reset : clock and synchronous active-high reset
//   i_valid        : sample present on the butterfly data input
//   o_ce           : butterfly input-register enable (combinational = i_valid)
//   o_ctr          : phase select, 00 fill/hold, 01 combine, 10 drain
//   o_wr, o_rd     : FIFO push / pop (FIFO is first-word-fall-through)
//   o_sof, o_eof   : first combine output / last drain output of a frame
//   o_busy         : controller holds frame state (not idle-and-empty)
module sdf_stage_ctrl #(
  parameter int unsigned M_WIDTH = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_valid,
  output logic       o_ce,
  output logic [1:0] o_ctr,
  output logic       o_wr,
  output logic       o_rd,
  output logic       o_sof,
  output logic       o_eof,
  output logic       o_busy
);

  localparam int unsigned FW = M_WIDTH + 1;
  localparam logic [FW-1:0]      DEPTH  = FW'(1 << M_WIDTH);
  localparam logic [FW-1:0]      F_LAST = FW'((2 << M_WIDTH) - 1);
  localparam logic [M_WIDTH-1:0] D_LAST = '1;

  localparam logic [1:0] CTR_HOLD  = 2'b00;
  localparam logic [1:0] CTR_COMB  = 2'b01;
  localparam logic [1:0] CTR_DRAIN = 2'b10;

  typedef enum logic [1:0] {IDLE, FILL, COMBINE, DRAIN} state_t;

  state_t             state;
  logic [FW-1:0]      fcnt;
  logic [M_WIDTH-1:0] dcnt;
  logic [FW-1:0]      fcnt_inc;

  assign o_ce = i_valid;

  // Fill count including the sample arriving this cycle.
  assign fcnt_inc = fcnt + FW'(i_valid);

  // Sequencer: state, counters and registered strobes.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= IDLE;
      fcnt   <= '0;
      dcnt   <= '0;
      o_ctr  <= CTR_HOLD;
      o_wr   <= 1'b0;
      o_rd   <= 1'b0;
      o_sof  <= 1'b0;
      o_eof  <= 1'b0;
      o_busy <= 1'b0;
    end else begin
      o_ctr  <= CTR_HOLD;
      o_wr   <= 1'b0;
      o_rd   <= 1'b0;
      o_sof  <= 1'b0;
      o_eof  <= 1'b0;
      o_busy <= 1'b1;
      case (state)
        IDLE: begin
          if (i_valid) begin
            o_wr  <= 1'b1;
            fcnt  <= fcnt_inc;
            state <= (fcnt_inc == DEPTH) ? COMBINE : FILL;
          end else begin
            o_busy <= 1'b0;
          end
        end
        FILL: begin
          if (i_valid) begin
            o_wr <= 1'b1;
            fcnt <= fcnt_inc;
            if (fcnt_inc == DEPTH) state <= COMBINE;
          end
        end
        COMBINE: begin
          // Invalid cycles stall here with every strobe low.
          if (i_valid) begin
            o_ctr <= CTR_COMB;
            o_wr  <= 1'b1;
            o_rd  <= 1'b1;
            o_sof <= (fcnt == DEPTH);
            if (fcnt == F_LAST) begin
              fcnt  <= '0;
              dcnt  <= '0;
              state <= DRAIN;
            end else begin
              fcnt <= fcnt_inc;
            end
          end
        end
        DRAIN: begin
          // Pop one difference per cycle. New-frame samples queue behind them.
          o_ctr <= CTR_DRAIN;
          o_rd  <= 1'b1;
          o_wr  <= i_valid;
          fcnt  <= fcnt_inc;
          dcnt  <= dcnt + M_WIDTH'(1);
          if (dcnt == D_LAST) begin
            o_eof <= 1'b1;
            if (fcnt_inc == '0) begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end else if (fcnt_inc == DEPTH) begin
              state <= COMBINE;
            end else begin
              state <= FILL;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sdf_stage_ctrl.md
# sdf_stage_ctrl

Per-stage sequencer for one radix-2 single-path delay-feedback (SDF) FWHT stage. It follows the input sample stream and produces the butterfly's phase select (`o_ctr`), FIFO write and read strobes, and input-register enable, plus frame markers for the next stage. A frame is 2·D samples, with D = 2^M_WIDTH equal to the butterfly FIFO depth. The block sits directly upstream of the butterfly and drives all of its control inputs.

## Interface
- `M_WIDTH`, default 2: log2 of the stage delay D; the FIFO depth is D and the frame length is 2·D.
- `i_clk`  in  1  clock.
- `i_reset`  in  1  synchronous, active-high reset; clock is `i_clk`.
- `i_valid`  in  1  sample present on the butterfly data input this cycle.
- `o_ce`  out  1  butterfly input-register enable; combinational, equal to `i_valid`.
- `o_ctr`  out  2  butterfly phase select, registered: 00 = fill/hold, 01 = combine, 10 = drain.
- `o_wr`  out  1  FIFO push, registered.
- `o_rd`  out  1  FIFO pop, registered.
- `o_sof`  out  1  first valid stage output of a frame (first combine cycle), registered.
- `o_eof`  out  1  last valid stage output of a frame (last drain cycle), registered.
- `o_busy`  out  1  high whenever the controller is not in IDLE with an empty fill count, registered.

## Operation
- Counters:
  - `fcnt` counts samples of the current frame; its range is [0, 2D).
  - `dcnt` counts drain reads of the previous frame; its range is [0, D).
- The FIFO is first-word-fall-through. `o_rd` pops at the clock edge and the head is visible combinationally.
- States and per-cycle registered outputs:
  - IDLE: `o_ctr`=00, `o_wr`=0, `o_rd`=0.
    - On `i_valid`: go to FILL and issue a push (`o_wr`=1, `fcnt`=1).
  - FILL (`fcnt` < D): each valid sample issues `o_wr`=1 with `o_ctr`=00.
    - An invalid cycle issues no strobes.
    - When `fcnt` reaches D, go to COMBINE.
  - COMBINE (D ≤ `fcnt` < 2D): each valid sample issues `o_ctr`=01, `o_wr`=1, `o_rd`=1.
    - The butterfly emits x_i + x_{i+D} and pushes x_i − x_{i+D}.
    - An invalid cycle issues `o_ctr`=00 with no strobes (stall).
    - After the 2D-th sample, set `fcnt`=0 and `dcnt`=0, then go to DRAIN.
  - DRAIN: every cycle issues `o_ctr`=10, `o_rd`=1, regardless of `i_valid`.
    - `o_wr` equals the registered `i_valid`, so new-frame samples are pushed behind the remaining differences; `fcnt` advances on each such push.
    - After D reads: if `fcnt` > 0, go to FILL (or COMBINE if `fcnt` = D); otherwise go to IDLE.
- Invariants:
  - FIFO occupancy never exceeds D.
  - FIFO occupancy is 0 at the end of a drain with no overlapping input.
  - `o_wr` and `o_rd` are never asserted when the FIFO is respectively full or empty.
- Frame markers:
  - `o_sof` is asserted with the first COMBINE strobe of a frame.
  - `o_eof` is asserted with the D-th DRAIN strobe.
- Reset mid-operation:
  - Discards the frame in progress and returns to IDLE with both counters at 0.
  - Resetting the FIFO pointers is the stage top's job; reset of the FIFO is done in the same cycle.

## Timing
- Reset values: `o_ctr`=00, `o_wr`=0, `o_rd`=0, `o_sof`=0, `o_eof`=0, `o_busy`=0. State is IDLE and both counters are 0.
- Latency: a sample with `i_valid` at cycle t is in the butterfly input register at t+1. The registered strobes for it are active at t+1, so the stage output for that sample is valid at t+1 (`o_ctr` ≠ 00).
- Drain strobes follow back-to-back on the D cycles after the last COMBINE strobe, with no bubbles.
- Simultaneous events:
  - `i_valid` during the last drain cycle is counted as a FILL sample of the next frame.
  - `i_reset` takes priority over `i_valid`.
- Throughput: 2D outputs per 2D inputs, so a continuous stream sustains 1 sample/cycle.

## Test plan
- M_WIDTH=2, continuous input 1,2,3,4,10,20,30,40:
  - Butterfly outputs 11,22,33,44 (`o_ctr`=01), then −9,−18,−27,−36 (`o_ctr`=10).
  - `o_sof` is asserted with the first of these outputs and `o_eof` with the last.
  - Returns to IDLE.
- Back-to-back frames of 8 samples:
  - The second frame's FILL overlaps the first frame's DRAIN (`o_wr`=`o_rd`=1).
  - Outputs have no gaps and occupancy stays ≤ 4.
- `i_valid` toggling 1/0 during FILL and COMBINE:
  - Stall cycles show `o_ctr`=00 and no strobes.
  - Results are identical to the continuous case.
- Input stops after one frame: DRAIN still completes 4 reads, then `o_busy`=0 and all strobes are 0.
- `i_reset` during COMBINE (after the 6th sample):
  - Next cycle all outputs are 0 and the state is IDLE.
  - A following fresh frame produces the correct sums and differences.
- M_WIDTH=3, ramp 0..15: outputs −8 ×8 after sums 8,10,…,22; `o_eof` occurs at output 16.
